// File: rtl/arm_pose_sequencer.sv
// Pose-table playback scheduler for the 4-servo arm: ramps each servo toward the current pose target per tick.
// Optional build macro ARM_SEQ_SOFTLIMIT_EN clamps targets into [PULSE_MIN, PULSE_MAX] when they are fetched.
module arm_pose_sequencer #(
    parameter int NPOSE       = 8,
    parameter int PW          = 17,
    parameter int STEP        = 200,
    parameter int TICK_DIV    = 250_000,
    parameter int DWELL_TICKS = 100,
    parameter int CENTER      = 62_500,
    parameter int PULSE_MIN   = 50_000,
    parameter int PULSE_MAX   = 75_000
) (
    input  logic                     CLOCK_50,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(NPOSE)-1:0] wr_pose,
    input  logic [1:0]               wr_servo,
    input  logic [PW-1:0]            wr_data,
    input  logic [$clog2(NPOSE)-1:0] last_pose,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    output logic [PW-1:0]            pulse0,
    output logic [PW-1:0]            pulse1,
    output logic [PW-1:0]            pulse2,
    output logic [PW-1:0]            pulse3,
    output logic [$clog2(NPOSE)-1:0] pose_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(NPOSE);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DWELL_TICKS + 1);
    localparam logic signed [PW:0] STEP_S = (PW+1)'(STEP);

    typedef enum logic [1:0] {IDLE, FETCH, RAMP, DWELL} state_t;

    state_t            state_r, state_n;
    logic [IW-1:0]     pose_r, pose_n;
    logic [CW-1:0]     dwell_r, dwell_n;
    logic [DW-1:0]     div_r;
    logic              tick_s, at_tgt_s, done_s, latch_s, ramp_s;
    logic              busy_r, done_r;
    logic [PW-1:0]     tbl_r [NPOSE][4];
    logic [PW-1:0]     cur_r [4];
    logic [PW-1:0]     tgt_r [4];

    // One ramp step: the difference is taken one bit wider and signed so the width never wraps.
    function automatic logic [PW-1:0] ramp_step(input logic [PW-1:0] cur, input logic [PW-1:0] tgt);
        logic signed [PW:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S) begin
            ramp_step = cur + PW'(STEP);
        end else if (diff < -STEP_S) begin
            ramp_step = cur - PW'(STEP);
        end else begin
            ramp_step = tgt;
        end
    endfunction

    // Target conditioning applied as a pose is fetched.
    function automatic logic [PW-1:0] limit_target(input logic [PW-1:0] t);
`ifdef ARM_SEQ_SOFTLIMIT_EN
        if (t < PW'(PULSE_MIN)) begin
            limit_target = PW'(PULSE_MIN);
        end else if (t > PW'(PULSE_MAX)) begin
            limit_target = PW'(PULSE_MAX);
        end else begin
            limit_target = t;
        end
`else
        limit_target = t;
`endif
    endfunction

    assign tick_s = (div_r == DW'(TICK_DIV - 1));

    // Free-running ramp tick divider, active in every state.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            div_r <= {DW{1'b0}};
        end else if (tick_s) begin
            div_r <= {DW{1'b0}};
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    // Pose table storage; deliberately not reset.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            tbl_r[wr_pose][wr_servo] <= wr_data;
        end
    end

    // All-servos-at-target detect.
    always_comb begin
        at_tgt_s = (cur_r[0] == tgt_r[0]) && (cur_r[1] == tgt_r[1]) &&
                   (cur_r[2] == tgt_r[2]) && (cur_r[3] == tgt_r[3]);
    end

    // Sequencer state register and registered status outputs.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_r <= IDLE;
            pose_r  <= {IW{1'b0}};
            dwell_r <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            pose_r  <= pose_n;
            dwell_r <= dwell_n;
            busy_r  <= (state_n != IDLE);
            done_r  <= done_s;
        end
    end

    // Next-state, pose advance and datapath strobes; stop overrides everything outside IDLE.
    always_comb begin
        state_n = state_r;
        pose_n  = pose_r;
        dwell_n = dwell_r;
        done_s  = 1'b0;
        latch_s = 1'b0;
        ramp_s  = 1'b0;
        if (stop && (state_r != IDLE)) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !stop) begin
                        state_n = FETCH;
                        pose_n  = {IW{1'b0}};
                    end else begin
                        state_n = IDLE;
                    end
                end
                FETCH: begin
                    latch_s = 1'b1;
                    state_n = RAMP;
                end
                RAMP: begin
                    ramp_s = tick_s;
                    if (at_tgt_s) begin
                        state_n = DWELL;
                        dwell_n = {CW{1'b0}};
                    end else begin
                        state_n = RAMP;
                    end
                end
                DWELL: begin
                    if (tick_s && (dwell_r == CW'(DWELL_TICKS - 1))) begin
                        if (pose_r != last_pose) begin
                            pose_n  = pose_r + IW'(1);
                            state_n = FETCH;
                        end else if (loop) begin
                            pose_n  = {IW{1'b0}};
                            state_n = FETCH;
                        end else begin
                            state_n = IDLE;
                            done_s  = 1'b1;
                        end
                    end else if (tick_s) begin
                        dwell_n = dwell_r + CW'(1);
                    end else begin
                        dwell_n = dwell_r;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Servo targets latched at fetch; current widths stepped on ticks while ramping.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cur_r[i] <= PW'(CENTER);
                tgt_r[i] <= PW'(CENTER);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (latch_s) begin
                    tgt_r[i] <= limit_target(tbl_r[pose_r][i]);
                end
                if (ramp_s) begin
                    cur_r[i] <= ramp_step(cur_r[i], tgt_r[i]);
                end
            end
        end
    end

    assign pulse0   = cur_r[0];
    assign pulse1   = cur_r[1];
    assign pulse2   = cur_r[2];
    assign pulse3   = cur_r[3];
    assign pose_idx = pose_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Directed self-checking bench for arm_pose_sequencer with a short tick (4 cycles) and 2-tick dwell.
module tb_arm_pose_sequencer;

    localparam int PW = 17;

    logic          CLOCK_50 = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_pose = 3'd0;
    logic [1:0]    wr_servo = 2'd0;
    logic [PW-1:0] wr_data = 17'd0;
    logic [2:0]    last_pose = 3'd0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] pulse0, pulse1, pulse2, pulse3;
    logic [2:0]    pose_idx;
    logic          busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    arm_pose_sequencer #(.TICK_DIV(4), .DWELL_TICKS(2)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .wr_en(wr_en), .wr_pose(wr_pose),
        .wr_servo(wr_servo), .wr_data(wr_data), .last_pose(last_pose), .loop(loop),
        .start(start), .stop(stop), .pulse0(pulse0), .pulse1(pulse1), .pulse2(pulse2),
        .pulse3(pulse3), .pose_idx(pose_idx), .busy(busy), .done(done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic tbl_write(input int pose, input int servo, input int data);
        wr_pose  = 3'(pose);
        wr_servo = 2'(servo);
        wr_data  = PW'(data);
        wr_en    = 1'b1;
        cycle();
        wr_en    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int n0, n1, n2, n3, step0, prev0, prev1, prev2, prev3, guard, d, done_cnt;
        int seq[$];
        bit loop_dropped;

        // Reset
        do_reset();
        check("rst_pulse0", pulse0, 62500);
        check("rst_pulse1", pulse1, 62500);
        check("rst_pulse2", pulse2, 62500);
        check("rst_pulse3", pulse3, 62500);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pose_idx", pose_idx, 0);

        // Single pose
        tbl_write(0, 0, 75000);
        tbl_write(0, 1, 50000);
        tbl_write(0, 2, 62500);
        tbl_write(0, 3, 62600);
        last_pose = 3'd0;
        loop = 1'b0;
        pulse_start();
        check("start_busy", busy, 1);
        n0 = 0; n1 = 0; n2 = 0; n3 = 0; step0 = 0; guard = 0;
        prev0 = pulse0; prev1 = pulse1; prev2 = pulse2; prev3 = pulse3;
        while (!(pulse0 == 75000 && pulse1 == 50000) && guard < 2000) begin
            cycle();
            guard++;
            if (pulse0 != prev0) begin n0++; step0 = int'(pulse0) - prev0; prev0 = pulse0; end
            if (pulse1 != prev1) begin n1++; prev1 = pulse1; end
            if (pulse2 != prev2) begin n2++; prev2 = pulse2; end
            if (pulse3 != prev3) begin n3++; prev3 = pulse3; end
        end
        check("single_ramp_timeout", int'(guard < 2000), 1);
        check("pulse0_ticks", n0, 63);
        check("pulse0_last_step", step0, 100);
        check("pulse1_ticks", n1, 63);
        check("pulse2_ticks", n2, 0);
        check("pulse3_ticks", n3, 1);
        check("pulse3_final", pulse3, 62600);
        d = 0;
        while (!done && d < 100) begin
            cycle();
            d++;
            check("busy_during_dwell", busy, done ? 0 : 1);
        end
        check("done_latency", d, 8);
        check("done_busy", busy, 0);
        cycle();
        check("done_one_cycle", done, 0);

        // Loop over poses 0,1 then drop loop
        tbl_write(1, 0, 74000);
        tbl_write(1, 1, 51000);
        tbl_write(1, 2, 62500);
        tbl_write(1, 3, 62600);
        last_pose = 3'd1;
        loop = 1'b1;
        pulse_start();
        seq.push_back(int'(pose_idx));
        done_cnt = 0; guard = 0; loop_dropped = 1'b0;
        while (guard < 3000) begin
            cycle();
            guard++;
            if (int'(pose_idx) != seq[$]) seq.push_back(int'(pose_idx));
            if (done) break;
            if (seq.size() == 4 && !loop_dropped) begin
                loop = 1'b0;
                loop_dropped = 1'b1;
            end
        end
        check("loop_done_seen", done, 1);
        check("loop_seq_len", seq.size(), 4);
        if (seq.size() == 4) begin
            check("loop_seq0", seq[0], 0);
            check("loop_seq1", seq[1], 1);
            check("loop_seq2", seq[2], 0);
            check("loop_seq3", seq[3], 1);
        end
        check("loop_done_pose", pose_idx, 1);
        check("loop_pulse0", pulse0, 74000);

        // Stop mid-ramp after 10 ticks on pose 0
        do_reset();
        check("rst2_pulse0", pulse0, 62500);
        check("rst2_pose_idx", pose_idx, 0);
        last_pose = 3'd0;
        pulse_start();
        n0 = 0; prev0 = pulse0; guard = 0;
        while (n0 < 10 && guard < 200) begin
            cycle();
            guard++;
            if (pulse0 != prev0) begin n0++; prev0 = pulse0; end
        end
        check("stop_ticks", n0, 10);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_pulse0", pulse0, 64500);
        check("stop_pulse1", pulse1, 60500);
        done_cnt = 0;
        repeat (20) begin
            cycle();
            if (done) done_cnt++;
        end
        check("stop_hold_pulse0", pulse0, 64500);
        check("stop_no_done", done_cnt, 0);

        // start and stop together from IDLE
        start = 1'b1;
        stop = 1'b1;
        cycle();
        start = 1'b0;
        stop = 1'b0;
        check("startstop_busy", busy, 0);
        repeat (10) cycle();
        check("startstop_busy_later", busy, 0);
        check("startstop_pulse0", pulse0, 64500);

        // Out-of-range targets; a mid-ramp write must not disturb the latched pose
        tbl_write(0, 0, 90000);
        tbl_write(0, 1, 10000);
        tbl_write(0, 2, 62500);
        tbl_write(0, 3, 62500);
        pulse_start();
        repeat (40) cycle();
        tbl_write(0, 2, 70000);
        guard = 0;
        while (!done && guard < 3000) begin
            cycle();
            guard++;
        end
        check("limit_done_seen", done, 1);
`ifdef ARM_SEQ_SOFTLIMIT_EN
        check("limit_pulse0", pulse0, 75000);
        check("limit_pulse1", pulse1, 50000);
`else
        check("limit_pulse0", pulse0, 90000);
        check("limit_pulse1", pulse1, 10000);
`endif
        check("latched_pulse2", pulse2, 62500);
        check("limit_pulse3", pulse3, 62500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
